adc_event_ring_buf: RTL

// Multi-event, multi-channel ADC sample ring buffer on adc_clk. Writes every valid parallel

---
 rtl/adc_event_ring_buf.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adc_event_ring_buf.sv
// Multi-channel ADC sample ring buffer with an L0 event descriptor queue; each
// queued window is read back from the ring and streamed out over valid/ready.
module adc_event_ring_buf #(
  parameter int unsigned N_CH  = 64,
  parameter int unsigned DW    = 12,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned EVQ   = 4,
  parameter int unsigned TSW   = 32
) (
  input  logic                     adc_clk,
  input  logic                     rst,
  input  logic [N_CH*DW-1:0]       adc_data,
  input  logic                     adc_valid,
  input  logic                     trig_l0,
  input  logic [$clog2(DEPTH)-1:0] trigger_latency,
  input  logic [$clog2(DEPTH)-1:0] n_samples,
  output logic [N_CH*DW-1:0]       out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     out_lost,
  output logic [15:0]              out_evt_num,
  output logic [$clog2(EVQ):0]     evt_pending,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              lost_cnt,
  output logic                     busy
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned QW = $clog2(EVQ);
  localparam logic [TSW-1:0] DepthTs = TSW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  state_e state_q, state_d;

  logic [N_CH*DW-1:0] mem [DEPTH];
  logic [TSW-1:0]     ts_q;
  logic               trig_q;

  // Event queue storage and occupancy
  logic [TSW-1:0] q_start [EVQ];
  logic [AW-1:0]  q_n     [EVQ];
  logic [15:0]    q_evt   [EVQ];
  logic [QW-1:0]  q_wr_q, q_rd_q;
  logic [QW:0]    q_cnt_q;
  logic           active_q;
  logic [15:0]    evt_num_q;

  // Current window
  logic [TSW-1:0] cur_start_q;
  logic [AW-1:0]  cur_n_q, k_q;
  logic [15:0]    cur_evt_q;

  // RAM read stage and 2-entry output skid
  logic [N_CH*DW-1:0] rd_data_q;
  logic               rd_vld_q, rd_sof_q, rd_eof_q, rd_lost_q;
  logic [15:0]        rd_evt_q;
  logic [N_CH*DW-1:0] sk_data [2];
  logic [18:0]        sk_meta [2];
  logic               sk_wr_q, sk_rd_q;
  logic [1:0]         sk_cnt_q;

  logic           trig_edge, full, push, drop, pop, evt_done, drain_done;
  logic           out_fire, room, rd_issue, last_k, age_future, age_lost;
  logic [TSW-1:0] word_ts, age;
  logic [2:0]     occ;

  assign evt_pending = q_cnt_q + {{QW{1'b0}}, active_q};
  assign trig_edge   = trig_l0 & ~trig_q;
  // The event being read out still holds one of the EVQ slots until it drains.
  assign full        = (evt_pending == (QW+1)'(EVQ));
  assign drain_done  = (sk_cnt_q == 2'd0) & ~rd_vld_q;
  assign evt_done    = (state_q == StDrain) & drain_done;
  assign push        = trig_edge & (n_samples != '0) & (~full | evt_done);
  assign drop        = trig_edge & (n_samples != '0) & full & ~evt_done;
  assign pop         = (state_q == StIdle) & (q_cnt_q != '0);

  assign word_ts    = cur_start_q + TSW'(k_q);
  assign age        = ts_q - word_ts;
  assign age_future = (age == '0) | age[TSW-1];
  assign age_lost   = ~age_future & (age >= DepthTs);
  assign last_k     = (k_q == cur_n_q - 1'b1);

  assign out_valid = (sk_cnt_q != 2'd0);
  assign out_fire  = out_valid & out_ready;
  // Credit: skid entries plus the read in flight, less the word leaving now.
  assign occ       = {1'b0, sk_cnt_q} + {2'b00, rd_vld_q} - {2'b00, out_fire};
  assign room      = (occ < 3'd2);
  assign rd_issue  = (state_q == StRun) & ~age_future & room;
  assign busy      = (state_q != StIdle);

  assign out_data = out_valid ? sk_data[sk_rd_q] : '0;
  assign {out_sof, out_eof, out_lost, out_evt_num} = out_valid ? sk_meta[sk_rd_q] : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StRun;
      StRun:   if (rd_issue && last_k) state_d = StDrain;
      StDrain: if (drain_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_valid) mem[ts_q[AW-1:0]] <= adc_data;
    if (rd_issue) rd_data_q <= mem[word_ts[AW-1:0]];
    if (push) begin
      q_start[q_wr_q] <= ts_q - TSW'(trigger_latency);
      q_n[q_wr_q]     <= n_samples;
      q_evt[q_wr_q]   <= evt_num_q;
    end
    if (rd_vld_q) begin
      sk_data[sk_wr_q] <= rd_data_q;
      sk_meta[sk_wr_q] <= {rd_sof_q, rd_eof_q, rd_lost_q, rd_evt_q};
    end
  end

  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ts_q        <= '0;
      trig_q      <= 1'b0;
      q_wr_q      <= '0;
      q_rd_q      <= '0;
      q_cnt_q     <= '0;
      active_q    <= 1'b0;
      evt_num_q   <= '0;
      cur_start_q <= '0;
      cur_n_q     <= '0;
      cur_evt_q   <= '0;
      k_q         <= '0;
      rd_vld_q    <= 1'b0;
      rd_sof_q    <= 1'b0;
      rd_eof_q    <= 1'b0;
      rd_lost_q   <= 1'b0;
      rd_evt_q    <= '0;
      sk_wr_q     <= 1'b0;
      sk_rd_q     <= 1'b0;
      sk_cnt_q    <= '0;
      drop_cnt    <= '0;
      lost_cnt    <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig_l0;
      if (adc_valid) ts_q <= ts_q + 1'b1;

      if (push) begin
        q_wr_q    <= q_wr_q + 1'b1;
        evt_num_q <= evt_num_q + 16'd1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      q_cnt_q <= q_cnt_q + {{QW{1'b0}}, push} - {{QW{1'b0}}, pop};

      if (pop) begin
        q_rd_q      <= q_rd_q + 1'b1;
        active_q    <= 1'b1;
        cur_start_q <= q_start[q_rd_q];
        cur_n_q     <= q_n[q_rd_q];
        cur_evt_q   <= q_evt[q_rd_q];
        k_q         <= '0;
      end else if (evt_done) begin
        active_q <= 1'b0;
      end else if (rd_issue) begin
        k_q <= k_q + 1'b1;
      end

      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_sof_q  <= (k_q == '0);
        rd_eof_q  <= last_k;
        rd_lost_q <= age_lost;
        rd_evt_q  <= cur_evt_q;
      end

      if (rd_vld_q) sk_wr_q <= ~sk_wr_q;
      if (out_fire) sk_rd_q <= ~sk_rd_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, out_fire};
      if (out_fire && out_lost && lost_cnt != 16'hFFFF) lost_cnt <= lost_cnt + 16'd1;
    end
  end

endmodule
